// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the ALU flag/condition path.
//   cond_t    - the 16 condition codes of the instruction encoding
//   flags_t   - architectural status flags, packed as {n,z,v,c}
//   cond_pass - evaluates a condition code against a flag set
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    function automatic logic cond_pass(input cond_t cc, input flags_t f);
        logic res;
        case (cc)
            COND_EQ: res = f.z;
            COND_NE: res = !f.z;
            COND_CS: res = f.c;
            COND_CC: res = !f.c;
            COND_MI: res = f.n;
            COND_PL: res = !f.n;
            COND_VS: res = f.v;
            COND_VC: res = !f.v;
            COND_HI: res = f.c && !f.z;
            COND_LS: res = !f.c || f.z;
            COND_GE: res = (f.n == f.v);
            COND_LT: res = (f.n != f.v);
            COND_GT: res = !f.z && (f.n == f.v);
            COND_LE: res = f.z || (f.n != f.v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;  // COND_NV
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_commit_fifo.sv
// alu_commit_fifo: 2-entry in-order valid/ready buffer.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - push side; in_ready depends only on stored state
//   in_data [WIDTH-1:0]   - pushed word
//   out_valid/out_ready   - pop side; head is driven straight from storage
//   out_data [WIDTH-1:0]  - head word (zero while empty)
module alu_commit_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  push, pop;

    // in_ready comes from count_q alone, so out_ready never reaches it
    // combinationally: a pop while full frees the slot for the next cycle.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_flag_commit.sv
// alu_flag_commit: consumer of the ALU result/flag interface.
// Evaluates the instruction condition against the architectural NZVC flags,
// commits the ALU flags when the condition passes and set_flags is asserted,
// and forwards {result, pass} through a 2-entry buffer.
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - ALU side handshake
//   resultado [N-1:0]             - ALU result
//   banNegativo/Cero/Desborde/Acarreo - ALU N/Z/V/C flags
//   cond [3:0], set_flags         - condition code, flag-update request
//   out_valid/out_ready           - writeback side handshake
//   out_resultado [N-1:0]         - head result
//   out_ejecutar                  - head condition passed (commit) / failed (annul)
//   flags_q [3:0]                 - architectural flags {N,Z,V,C}
//   anulados [CNT_W-1:0]          - saturating count of annulled ops
module alu_flag_commit
    import cpu_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     resultado,
    input  logic             banNegativo,
    input  logic             banCero,
    input  logic             banDesborde,
    input  logic             banAcarreo,
    input  logic [3:0]       cond,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_resultado,
    output logic             out_ejecutar,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] anulados
);

    logic [3:0]       flags_d;
    logic [CNT_W-1:0] anulados_q, anulados_d;
    logic             xfer, pass;
    logic [N:0]       fifo_out;

    assign anulados = anulados_q;
    assign xfer     = in_valid && in_ready;

    // Evaluated on the current register, so each transfer sees the flags
    // written by the one before it with no bubble.
    assign pass = cond_pass(cond_t'(cond), flags_t'(flags_q));

    always_comb begin
        flags_d    = flags_q;
        anulados_d = anulados_q;
        if (xfer) begin
            if (pass && set_flags) begin
                flags_d = {banNegativo, banCero, banDesborde, banAcarreo};
            end
            if (!pass && (anulados_q != {CNT_W{1'b1}})) begin
                anulados_d = anulados_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= 4'b0000;
            anulados_q <= '0;
        end else begin
            flags_q    <= flags_d;
            anulados_q <= anulados_d;
        end
    end

    alu_commit_fifo #(
        .WIDTH(N + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({resultado, pass}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (fifo_out)
    );

    assign out_resultado = fifo_out[N:1];
    assign out_ejecutar  = fifo_out[0];

endmodule

// File: tb/tb_alu_flag_commit.sv
// Testbench for alu_flag_commit: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level model
// (queue of pending results, flag register, annul counter).
module tb_alu_flag_commit;

    localparam int N     = 32;
    localparam int CNT_W = 4;  // small so saturation is reachable quickly

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     resultado = '0;
    logic             banNegativo = 1'b0, banCero = 1'b0, banDesborde = 1'b0, banAcarreo = 1'b0;
    logic [3:0]       cond = 4'h0;
    logic             set_flags = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_resultado;
    logic             out_ejecutar;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] anulados;

    always #5 clk = !clk;

    alu_flag_commit #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .resultado    (resultado),
        .banNegativo  (banNegativo),
        .banCero      (banCero),
        .banDesborde  (banDesborde),
        .banAcarreo   (banAcarreo),
        .cond         (cond),
        .set_flags    (set_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_resultado(out_resultado),
        .out_ejecutar (out_ejecutar),
        .flags_q      (flags_q),
        .anulados     (anulados)
    );

    typedef struct {
        logic [N-1:0] r;
        logic         p;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_flags = 4'b0;
    int         m_cnt = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Condition truth, stated directly from the architectural definitions.
    function automatic bit ref_pass(input int cc, input logic [3:0] f);
        bit n, z, v, c;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (cc)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_state();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_resultado", out_resultado, q[0].r);
            chk("out_ejecutar", out_ejecutar, q[0].p);
        end
        chk("flags_q", flags_q, m_flags);
        chk("anulados", anulados, m_cnt);
    endtask

    // One clock: drive inputs, advance model across the edge, check at negedge.
    task automatic step(input bit r, input bit iv, input logic [N-1:0] res,
                        input logic [3:0] fl, input logic [3:0] cc,
                        input bit sf, input bit ordy);
        bit do_x, do_pop, p;
        rst = r; in_valid = iv; resultado = res;
        {banNegativo, banCero, banDesborde, banAcarreo} = fl;
        cond = cc; set_flags = sf; out_ready = ordy;
        do_x   = iv && (q.size() < 2);
        do_pop = ordy && (q.size() > 0);
        p      = ref_pass(int'(cc), m_flags);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_flags = 4'b0;
            m_cnt   = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_x) begin
                q.push_back('{r: res, p: p});
                if (p && sf) m_flags = fl;
                if (!p && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_res"}, out_resultado, 0);
        chk({tag, "_out_ej"}, out_ejecutar, 1'b0);
        chk({tag, "_flags"}, flags_q, 4'b0);
        chk({tag, "_anul"}, anulados, 0);
    endtask

    initial begin
        step(1, 0, 0, 4'h0, 4'h0, 0, 0);
        step(1, 0, 0, 4'h0, 4'h0, 0, 0);
        check_reset_state("rst");

        // Simple always-execute transfer, one-cycle latency.
        step(0, 1, 75, 4'b0000, 4'hE, 1, 1);
        chk("first_res", out_resultado, 75);
        chk("first_ej", out_ejecutar, 1'b1);

        // Z,C set; EQ passes, NE annuls.
        step(0, 1, 0, 4'b0101, 4'hE, 1, 1);
        chk("zc_flags", flags_q, 4'b0101);
        step(0, 1, 90, 4'b0000, 4'h0, 0, 1);
        chk("eq_ej", out_ejecutar, 1'b1);
        step(0, 1, 91, 4'b1111, 4'h1, 1, 1);
        chk("ne_ej", out_ejecutar, 1'b0);
        chk("ne_anul", anulados, 1);
        chk("ne_flags", flags_q, 4'b0101);

        // N=1,V=0: LT passes and clears flags, then LT annuls.
        step(0, 1, 5, 4'b1000, 4'hE, 1, 1);
        step(0, 1, 6, 4'b0000, 4'hB, 1, 1);
        chk("lt1_ej", out_ejecutar, 1'b1);
        chk("lt1_flags", flags_q, 4'b0000);
        step(0, 1, 7, 4'b0000, 4'hB, 0, 1);
        chk("lt2_ej", out_ejecutar, 1'b0);
        step(0, 0, 0, 4'h0, 4'h0, 0, 1);

        // Backpressure: 10, 20 fill, 30 refused; head holds.
        step(0, 1, 10, 4'h0, 4'hE, 0, 0);
        step(0, 1, 20, 4'h0, 4'hE, 0, 0);
        chk("bp_full", in_ready, 1'b0);
        step(0, 1, 30, 4'h0, 4'hE, 0, 0);
        step(0, 1, 30, 4'h0, 4'hE, 0, 0);
        chk("bp_hold", out_resultado, 10);
        step(0, 1, 30, 4'h0, 4'hE, 0, 1);
        chk("bp_second", out_resultado, 20);
        step(0, 1, 30, 4'h0, 4'hE, 0, 1);
        chk("bp_third", out_resultado, 30);
        step(0, 0, 0, 4'h0, 4'hE, 0, 1);
        chk("bp_empty", out_valid, 1'b0);

        // NV never executes, flags untouched.
        step(0, 1, 1, 4'b1111, 4'hF, 1, 1);
        chk("nv_ej", out_ejecutar, 1'b0);
        chk("nv_flags", flags_q, 4'b0000);

        // Two entries buffered, then reset.
        step(0, 1, 11, 4'b1010, 4'hE, 1, 0);
        step(0, 1, 12, 4'b0000, 4'hF, 0, 0);
        step(1, 0, 0, 4'h0, 4'h0, 0, 0);
        check_reset_state("midrst");
        step(0, 0, 0, 4'h0, 4'h0, 0, 1);

        // Counter saturation.
        for (int i = 0; i < 20; i++) step(0, 1, i, 4'h0, 4'hF, 0, 1);
        chk("sat", anulados, {CNT_W{1'b1}});
        step(1, 0, 0, 4'h0, 4'h0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom(),
                 4'($urandom()), 4'($urandom()), 1'($urandom()),
                 ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_flag_commit.md
Name: alu_flag_commit

Overview:
- Consumer end of the ALU result/flag interface: takes each ALU result plus its four flags (Negativo, Cero, Desborde, Acarreo).
- Evaluates a 4-bit condition code against the architectural NZVC status register and conditionally commits the flags.
- Forwards the result, tagged execute/annul, through a 2-entry output buffer with valid/ready on both sides.
- Sits between the ALU and writeback/branch logic in the CPU.

Parameters:
- N, 32, result width (matches ALU width parameter).
- CNT_W, 16, width of the annulled-op counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result/flags/cond valid this cycle.
- in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready.
- resultado  input  N  ALU result C.
- banNegativo  input  1  ALU N flag.
- banCero  input  1  ALU Z flag.
- banDesborde  input  1  ALU V flag.
- banAcarreo  input  1  ALU C flag.
- cond  input  4  condition code of the instruction.
- set_flags  input  1  instruction requests a flag update.
- out_valid  output  1  head of buffer valid.
- out_ready  input  1  downstream accepts head.
- out_resultado  output  N  head result.
- out_ejecutar  output  1  head condition passed (1 = commit, 0 = annul).
- flags_q  output  4  architectural flags {N,Z,V,C}.
- anulados  output  CNT_W  count of annulled ops; saturates.

Behaviour:
- Reset (rst=1 at edge): flags_q=4'b0000; buffer empty (out_valid=0, out_resultado=0, out_ejecutar=0); anulados=0; in_ready=1 during the cycle after reset.
- Condition codes evaluated on flags_q (state *before* this transfer):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- On transfer:
  - pass = eval(cond, flags_q).
  - If pass && set_flags, flags_q <= {banNegativo, banCero, banDesborde, banAcarreo} at that edge. Otherwise flags_q is unchanged.
  - Entry {resultado, pass} is pushed to the buffer.
  - If !pass, anulados increments, saturating at all-ones.
- Back-to-back transfers: transfer k+1 evaluates on flags written by transfer k. No extra bubble.
- Buffer: 2-entry FIFO, in-order.
  - in_ready = !full. It is registered-state derived with no combinational path from out_ready.
  - out_valid = !empty; head is presented combinationally from storage.
  - Simultaneous push and pop when full: push is refused because in_ready=0. Pop occurs; in_ready rises next cycle.
  - Simultaneous push and pop with 1 entry: occupancy stays 1, order preserved.
  - Read/write pointers wrap modulo 2.
- Latency: result appears at out_* one cycle after transfer when the buffer was empty.
- Output stability: head data and out_valid hold stable while out_valid && !out_ready.
- rst mid-stream: buffered entries are discarded; flags and counter are cleared; no output the following cycle.
- No arithmetic on resultado; it passes through unchanged at width N.

Decomposition:
- Shared package cpu_pkg holds:
  - cond_t enum for the 16 codes.
  - flags_t packed struct {n,z,v,c}.
  - Function cond_pass(cond_t, flags_t).
- Sub-module alu_commit_fifo: 2-entry valid/ready FIFO, parameter WIDTH = N+1.

Test Plan:
- Reset, then push resultado=75, flags 0000, cond=E, set_flags=1 -> next cycle out_resultado=75, out_ejecutar=1, flags_q=0000.
- Push 45-45=0 with Z=1, C=1, cond=E, set_flags=1; then push 90 with cond=0 (EQ) -> flags_q=0101, second out_ejecutar=1; push cond=1 (NE) -> out_ejecutar=0, anulados=1, flags_q unchanged.
- flags_q N=1, V=0: push cond=B (LT) set_flags=1 with flags 0000 -> passes, flags_q=0000; then cond=B -> annulled.
- Hold out_ready=0, push 3 values (10, 20, 30) -> in_ready=0 after 2; out_resultado stays 10; release -> 10, 20 emerge in order; 30 is accepted once in_ready=1.
- cond=F with set_flags=1 and flags 1111 -> annulled, flags_q unchanged, anulados increments.
- Two entries buffered, assert rst for one cycle -> out_valid=0, flags_q=0, anulados=0, in_ready=1.
